// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the IF/ID and ID/EX registers: load-use and HI/LO stalls,
// branch/jump flushes, mult/div busy tracking and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LAT  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic                   ID_ReadRs,
    input  logic                   ID_ReadRt,
    input  logic                   ID_Jump,
    input  logic                   ID_MulDiv,
    input  logic                   ID_ReadHiLo,
    input  logic                   EX_MemRead,
    input  logic [4:0]             EX_Rt,
    input  logic                   EX_BranchTaken,
    output logic                   PC_wen,
    output logic                   IF_ID_wen,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Flush,
    output logic                   MulDiv_busy,
    output logic [STALL_CNT_W-1:0] Stall_cnt
);
    localparam int MD_W = $clog2(MULDIV_LAT + 1);

    typedef enum logic {S_RUN, S_BUSY} state_e;

    state_e                 state_q;
    logic [MD_W-1:0]        md_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic load_use, hilo_haz, stall, md_issue;

    assign MulDiv_busy = (state_q == S_BUSY);

    assign load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((ID_ReadRs && (ID_Rs == EX_Rt)) || (ID_ReadRt && (ID_Rt == EX_Rt)));
    assign hilo_haz = MulDiv_busy && (ID_ReadHiLo || ID_MulDiv);
    assign stall    = (load_use || hilo_haz) && !EX_BranchTaken;
    assign md_issue = ID_MulDiv && !stall && !EX_BranchTaken;

    // Taken branch outranks any stall; a stalled jump waits before flushing IF/ID.
    always_comb begin
        PC_wen      = 1'b1;
        IF_ID_wen   = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (stall) begin
            PC_wen      = 1'b0;
            IF_ID_wen   = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (ID_Jump) begin
            IF_ID_Flush = 1'b1;
        end
        if (!reset) begin
            PC_wen      = 1'b0;
            IF_ID_wen   = 1'b0;
            IF_ID_Flush = 1'b0;
            ID_EX_Flush = 1'b0;
        end
    end

    // Busy FSM: issue only from S_RUN, since hilo_haz blocks issue while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RUN;
            md_cnt_q <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (md_issue) begin
                        state_q  <= S_BUSY;
                        md_cnt_q <= MD_W'(MULDIV_LAT);
                    end
                end
                S_BUSY: begin
                    if (md_cnt_q == MD_W'(1)) begin
                        state_q  <= S_RUN;
                        md_cnt_q <= '0;
                    end else begin
                        md_cnt_q <= md_cnt_q - MD_W'(1);
                    end
                end
                default: begin
                    state_q  <= S_RUN;
                    md_cnt_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end

    assign Stall_cnt = stall_cnt_q;

endmodule
